// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared encodings for the parametrised register file: stack-op
//            codes and architectural register indices.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

   // Stack-pointer operation codes carried on spOp; 2'b11 is reserved (no-op)
   localparam logic [1:0] SPOP_NONE = 2'b00;
   localparam logic [1:0] SPOP_PUSH = 2'b01;
   localparam logic [1:0] SPOP_POP  = 2'b10;

   // Architectural register indices
   localparam int REG_M  = 0;
   localparam int REG_RA = 1;
   localparam int REG_SP = 2;
   localparam int REG_AT = 3;
   localparam int REG_T0 = 4;
   localparam int REG_T1 = 5;
   localparam int REG_T2 = 6;
   localparam int REG_S  = 7;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_param_if.sv
// ============================================================================
// Module   : regfile_param_if
// Purpose  : Bundles the read, write and stack-op signals of the register
//            file. The master (decode side) drives indices, write data and
//            spOp; the slave (register file) returns read data, m, spOut
//            and stkErr.
// Ports    : none (signals listed below, directions given by modports)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_param_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic [ADDR_W-1:0] r1;
   logic [ADDR_W-1:0] r2;
   logic [ADDR_W-1:0] wDest;
   logic [DATA_W-1:0] wDat;
   logic              regWrt;
   logic [1:0]        spOp;
   logic [DATA_W-1:0] r1out;
   logic [DATA_W-1:0] r2out;
   logic [DATA_W-1:0] m;
   logic [DATA_W-1:0] spOut;
   logic              stkErr;

   modport master (
      output r1, r2, wDest, wDat, regWrt, spOp,
      input  r1out, r2out, m, spOut, stkErr
   );

   modport slave (
      input  r1, r2, wDest, wDat, regWrt, spOp,
      output r1out, r2out, m, spOut, stkErr
   );

endinterface : regfile_param_if

`default_nettype wire

// File: rtl/sp_ctrl.sv
// ============================================================================
// Module   : sp_ctrl
// Purpose  : Combinational stack-pointer update logic. Computes the next SP
//            for push/pop, enables the SP update only when the operation is
//            within bounds, and pulses an error for an out-of-bounds op.
// Ports    : sp      in  DATA_W  current SP value
//            sp_op   in  2       stack op code
//            wr_sp   in  1       explicit write to SP this cycle (overrides)
//            sp_next out DATA_W  next SP value
//            sp_en   out 1       SP update enable
//            err     out 1       bound-violation pulse
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sp_ctrl
   import regfile_pkg::*;
#(
   parameter int              DATA_W  = 16,
   parameter logic [DATA_W-1:0] SP_STEP = 16'd2,
   parameter logic [DATA_W-1:0] SP_MIN  = 16'h0000,
   parameter logic [DATA_W-1:0] SP_MAX  = 16'hFFFE
) (
   input  wire logic [DATA_W-1:0] sp,
   input  wire logic [1:0]        sp_op,
   input  wire logic              wr_sp,
   output logic      [DATA_W-1:0] sp_next,
   output logic                   sp_en,
   output logic                   err
);

   // Bounds are evaluated one bit wider than the datapath so neither
   // SP_MIN + SP_STEP nor SP + SP_STEP can wrap around.
   logic [DATA_W:0] w_sp_ext;
   logic [DATA_W:0] w_push_floor;
   logic [DATA_W:0] w_pop_sum;
   logic            w_push_ok;
   logic            w_pop_ok;

   assign w_sp_ext     = {1'b0, sp};
   assign w_push_floor = {1'b0, SP_MIN} + {1'b0, SP_STEP};
   assign w_pop_sum    = w_sp_ext + {1'b0, SP_STEP};
   assign w_push_ok    = (w_sp_ext >= w_push_floor);
   assign w_pop_ok     = (w_pop_sum <= {1'b0, SP_MAX});

   always_comb begin
      sp_next = sp;
      sp_en   = 1'b0;
      err     = 1'b0;
      // An explicit write to SP takes priority: the stack op is dropped
      // entirely, including its bound check.
      if (!wr_sp) begin
         case (sp_op)
            SPOP_PUSH: begin
               if (w_push_ok) begin
                  sp_next = sp - SP_STEP;
                  sp_en   = 1'b1;
               end else begin
                  err = 1'b1;
               end
            end
            SPOP_POP: begin
               if (w_pop_ok) begin
                  sp_next = w_pop_sum[DATA_W-1:0];
                  sp_en   = 1'b1;
               end else begin
                  err = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule : sp_ctrl

`default_nettype wire

// File: rtl/regfile_param.sv
// ============================================================================
// Module   : regfile_param
// Purpose  : Parametrised register file with two combinational read ports
//            (write-first bypass), one synchronous write port, exported M
//            and SP registers, and a bounds-checked hardware stack pointer
//            with a sticky error flag.
// Ports    : clk    in  1  clock, rising edge
//            reset  in  1  asynchronous active-high reset
//            bus    slave modport of regfile_param_if
//                   (r1, r2, wDest, wDat, regWrt, spOp in;
//                    r1out, r2out, m, spOut, stkErr out)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_param
   import regfile_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 3,
   parameter int                M_IDX    = REG_M,
   parameter int                SP_IDX   = REG_SP,
   parameter logic [DATA_W-1:0] SP_STEP  = 16'd2,
   parameter logic [DATA_W-1:0] SP_RESET = 16'hFFFE,
   parameter logic [DATA_W-1:0] SP_MIN   = 16'h0000,
   parameter logic [DATA_W-1:0] SP_MAX   = 16'hFFFE
) (
   input  wire logic      clk,
   input  wire logic      reset,
   regfile_param_if.slave bus
);

   localparam int NUM_REGS = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] c_sp_addr = ADDR_W'(SP_IDX);

   generate
      if (SP_MIN > SP_RESET || SP_RESET > SP_MAX) begin : g_chk_sp_range
         $error("regfile_param: SP_RESET outside [SP_MIN, SP_MAX]");
      end
      if (SP_STEP == '0) begin : g_chk_sp_step
         $error("regfile_param: SP_STEP must be non-zero");
      end
      if (M_IDX < 0 || M_IDX >= NUM_REGS || SP_IDX < 0 || SP_IDX >= NUM_REGS) begin : g_chk_idx
         $error("regfile_param: M_IDX/SP_IDX out of range");
      end
   endgenerate

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic              r_stk_err;

   logic [DATA_W-1:0] w_sp_next;
   logic              w_sp_en;
   logic              w_sp_err;
   logic              w_wr_sp;

   assign w_wr_sp = bus.regWrt && (bus.wDest == c_sp_addr);

   sp_ctrl #(
      .DATA_W  (DATA_W),
      .SP_STEP (SP_STEP),
      .SP_MIN  (SP_MIN),
      .SP_MAX  (SP_MAX)
   ) u_sp_ctrl (
      .sp      (r_regs[SP_IDX]),
      .sp_op   (bus.spOp),
      .wr_sp   (w_wr_sp),
      .sp_next (w_sp_next),
      .sp_en   (w_sp_en),
      .err     (w_sp_err)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
         end
         r_stk_err <= 1'b0;
      end else begin
         if (bus.regWrt) begin
            r_regs[bus.wDest] <= bus.wDat;
         end
         // sp_en is already suppressed whenever the write port targets SP,
         // so these two updates never hit the same register.
         if (w_sp_en) begin
            r_regs[SP_IDX] <= w_sp_next;
         end
         if (w_sp_err) begin
            r_stk_err <= 1'b1;
         end
      end
   end

   // Write-first bypass from the explicit write port only
   assign bus.r1out  = (bus.regWrt && bus.wDest == bus.r1) ? bus.wDat : r_regs[bus.r1];
   assign bus.r2out  = (bus.regWrt && bus.wDest == bus.r2) ? bus.wDat : r_regs[bus.r2];
   assign bus.m      = r_regs[M_IDX];
   assign bus.spOut  = r_regs[SP_IDX];
   assign bus.stkErr = r_stk_err;

endmodule : regfile_param

`default_nettype wire

// File: tb/tb_regfile_param.sv
// ============================================================================
// Module   : tb_regfile_param
// Purpose  : Directed self-checking bench for regfile_param.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_param;
   import regfile_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   regfile_param_if #(.DATA_W(16), .ADDR_W(3)) bus ();

   regfile_param u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Apply a full set of inputs, then let combinational paths settle
   task automatic drive(input logic wr, input logic [2:0] dest, input logic [15:0] dat,
                        input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
      bus.regWrt = wr;
      bus.wDest  = dest;
      bus.wDat   = dat;
      bus.spOp   = op;
      bus.r1     = a;
      bus.r2     = b;
      #1;
   endtask

   task automatic idle(input logic [2:0] a, input logic [2:0] b);
      drive(1'b0, 3'd0, 16'h0000, SPOP_NONE, a, b);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Assert reset in the middle of a cycle; state must clear immediately
   task automatic mid_reset();
      idle(3'd3, 3'd5);
      #1;
      reset = 1'b1;
      #1;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      bus.regWrt = 1'b0;
      bus.wDest  = '0;
      bus.wDat   = '0;
      bus.spOp   = SPOP_NONE;
      bus.r1     = '0;
      bus.r2     = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      idle(3'd3, 3'd2);
      check("rst_spout", bus.spOut, 16'hFFFE);
      check("rst_m", bus.m, 16'h0000);
      check("rst_stkerr", {15'd0, bus.stkErr}, 16'd0);
      check("rst_r1_idx3", bus.r1out, 16'h0000);
      check("rst_r2_sp", bus.r2out, 16'hFFFE);

      // Dual-port bypass then array read
      drive(1'b1, 3'd5, 16'hBEEF, SPOP_NONE, 3'd5, 3'd5);
      check("byp_r1", bus.r1out, 16'hBEEF);
      check("byp_r2", bus.r2out, 16'hBEEF);
      tick();
      idle(3'd5, 3'd5);
      check("arr_r1", bus.r1out, 16'hBEEF);
      check("arr_r2", bus.r2out, 16'hBEEF);

      // M register: no bypass on m, bypass on read port
      drive(1'b1, 3'd0, 16'h1234, SPOP_NONE, 3'd0, 3'd1);
      check("m_before", bus.m, 16'h0000);
      check("m_byp_r1", bus.r1out, 16'h1234);
      tick();
      idle(3'd0, 3'd1);
      check("m_after", bus.m, 16'h1234);

      // Push x3, pop x1
      drive(1'b0, 3'd0, 16'h0000, SPOP_PUSH, 3'd2, 3'd0);
      tick();
      check("push1", bus.spOut, 16'hFFFC);
      tick();
      check("push2", bus.spOut, 16'hFFFA);
      tick();
      check("push3", bus.spOut, 16'hFFF8);
      drive(1'b0, 3'd0, 16'h0000, SPOP_POP, 3'd2, 3'd0);
      tick();
      idle(3'd2, 3'd0);
      check("pop1", bus.spOut, 16'hFFFA);
      check("pop1_r1", bus.r1out, 16'hFFFA);
      check("pushpop_err", {15'd0, bus.stkErr}, 16'd0);

      // Reserved op: no change, no error
      drive(1'b0, 3'd0, 16'h0000, 2'b11, 3'd2, 3'd0);
      tick();
      check("op11_sp", bus.spOut, 16'hFFFA);
      check("op11_err", {15'd0, bus.stkErr}, 16'd0);

      // Mid-cycle asynchronous reset after writes
      drive(1'b1, 3'd3, 16'h5555, SPOP_NONE, 3'd3, 3'd5);
      tick();
      mid_reset();
      check("mrst_spout", bus.spOut, 16'hFFFE);
      check("mrst_m", bus.m, 16'h0000);
      check("mrst_err", {15'd0, bus.stkErr}, 16'd0);
      check("mrst_r1_idx3", bus.r1out, 16'h0000);
      check("mrst_r2_idx5", bus.r2out, 16'h0000);
      release_reset();

      // Pop at SP_MAX: illegal, SP holds, sticky error
      drive(1'b0, 3'd0, 16'h0000, SPOP_POP, 3'd2, 3'd0);
      tick();
      check("popmax_sp", bus.spOut, 16'hFFFE);
      check("popmax_err", {15'd0, bus.stkErr}, 16'd1);
      drive(1'b0, 3'd0, 16'h0000, SPOP_PUSH, 3'd2, 3'd0);
      tick();
      check("push_after_err_sp", bus.spOut, 16'hFFFC);
      check("push_after_err_err", {15'd0, bus.stkErr}, 16'd1);

      // Push at SP_MIN: illegal
      mid_reset();
      release_reset();
      drive(1'b1, 3'd2, 16'h0000, SPOP_NONE, 3'd2, 3'd0);
      tick();
      check("sp0_written", bus.spOut, 16'h0000);
      drive(1'b0, 3'd0, 16'h0000, SPOP_PUSH, 3'd2, 3'd0);
      tick();
      check("pushmin_sp", bus.spOut, 16'h0000);
      check("pushmin_err", {15'd0, bus.stkErr}, 16'd1);

      // Explicit SP write wins over a same-cycle push, and SP=0 must not
      // trigger a bound check for that dropped push
      mid_reset();
      release_reset();
      drive(1'b1, 3'd2, 16'h0000, SPOP_NONE, 3'd2, 3'd0);
      tick();
      drive(1'b1, 3'd2, 16'h0100, SPOP_PUSH, 3'd2, 3'd0);
      check("wrsp_byp", bus.r1out, 16'h0100);
      tick();
      idle(3'd2, 3'd0);
      check("wrsp_sp", bus.spOut, 16'h0100);
      check("wrsp_err", {15'd0, bus.stkErr}, 16'd0);

      // Write to another register concurrent with a pop
      drive(1'b1, 3'd4, 16'hA5A5, SPOP_POP, 3'd4, 3'd2);
      tick();
      idle(3'd4, 3'd2);
      check("conc_r1", bus.r1out, 16'hA5A5);
      check("conc_sp", bus.spOut, 16'h0102);
      check("conc_err", {15'd0, bus.stkErr}, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_regfile_param

`default_nettype wire
